// File: rtl/mips32_if.sv
// mips32_if: data-memory bus between the pipeline MEM stage and the data RAM
interface mips32_if;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    modport master (output addr, wdata, we, input rdata);
    modport slave (input addr, wdata, we, output rdata);
endinterface

// File: rtl/mips32.sv
// mips32: 5-stage word-addressed pipeline; define MIPS32_FORWARD_EN for the EX bypass paths
module mips32_imem (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] ir
);
    logic [31:0] mem [0:1023];
    assign ir = mem[addr];
    // program load port; the core ties it off because programs are preloaded
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
endmodule

module mips32_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    input  logic [4:0]  rc,
    input  logic [31:0] wd,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [31:0] qc
);
    logic [31:0] reg_b [0:31];
    assign qa = ra == 5'd0 ? 32'd0 : (we && ra == wa) ? wd : reg_b[ra];
    assign qb = rb == 5'd0 ? 32'd0 : (we && rb == wa) ? wd : reg_b[rb];
    assign qc = rc == 5'd0 ? 32'd0 : (we && rc == wa) ? wd : reg_b[rc];
    // WB write port; R0 is never written and nothing is written while in reset
    always_ff @(posedge clk)
        if (we && !rst && wa != 5'd0) reg_b[wa] <= wd;
endmodule

module mips32_dmem (
    input logic     clk,
    input logic     rst,
    mips32_if.slave bus
);
    logic [31:0] data [0:1023];
    assign bus.rdata = data[bus.addr];
    // store port, suppressed while in reset
    always_ff @(posedge clk)
        if (bus.we && !rst) data[bus.addr] <= bus.wdata;
endmodule

module mips32 (
    input logic clk_x,
    input logic rst
);
    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010, OP_OR = 6'b000011;
    localparam logic [5:0] OP_SLT = 6'b000100, OP_MUL = 6'b000101, OP_ADDI = 6'b001010, OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100, OP_MULI = 6'b010010, OP_LW = 6'b110000, OP_SW = 6'b110001;
    localparam logic [5:0] OP_BEQZ = 6'b110100, OP_BNEQZ = 6'b110101, OP_HLT = 6'b111111;
`ifdef MIPS32_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif
    logic [9:0]  pc, fd_npc, de_npc;
    logic [31:0] fd_ir, de_ir, de_a, de_b, de_s, em_alu, em_sd, mw_res;
    logic [4:0]  em_dst, mw_dst;
    logic        em_wr, em_ld, em_st, em_hlt, mw_wr, halted, stop;
    logic [31:0] f_ir, qa, qb, qc, x, y, s, alu;
    logic [5:0]  op;
    logic        taken, stall, fd_hlt;
    mips32_if bus ();

    mips32_imem i_f (.clk(clk_x), .we(1'b0), .addr(pc), .wdata(32'd0), .ir(f_ir));
    mips32_regs id (.clk(clk_x), .rst(rst), .we(mw_wr), .wa(mw_dst), .ra(fd_ir[25:21]), .rb(fd_ir[20:16]),
                    .rc(fd_ir[15:11]), .wd(mw_res), .qa(qa), .qb(qb), .qc(qc));
    mips32_dmem max (.clk(clk_x), .rst(rst), .bus(bus));

    function automatic logic is_r(input logic [5:0] o);
        return o <= OP_MUL;
    endfunction

    function automatic logic is_i(input logic [5:0] o);
        return o == OP_ADDI || o == OP_SUBI || o == OP_SLTI || o == OP_MULI;
    endfunction

    function automatic logic writes(input logic [31:0] ir);
        return (is_r(ir[31:26]) || is_i(ir[31:26]) || ir[31:26] == OP_LW) && ir[25:21] != 5'd0;
    endfunction

    function automatic logic reads(input logic [31:0] ir, input logic [4:0] r);
        logic [5:0] o;
        o = ir[31:26];
        return r != 5'd0 && ((((is_r(o) || is_i(o) || o == OP_LW || o == OP_SW || o == OP_BEQZ || o == OP_BNEQZ)
               && ir[20:16] == r) || (is_r(o) && ir[15:11] == r) || (o == OP_SW && ir[25:21] == r)));
    endfunction

    // EX operand bypass from EX/MEM then MEM/WB; a load in EX/MEM never reaches here thanks to the load-use stall
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        return (FWD && em_wr && em_dst == r) ? em_alu : (FWD && mw_wr && mw_dst == r) ? mw_res : v;
    endfunction

    assign op = de_ir[31:26];
    assign x = fwd(de_ir[20:16], de_a);
    assign y = is_r(op) ? fwd(de_ir[15:11], de_b) : {{16{de_ir[15]}}, de_ir[15:0]};
    assign s = fwd(de_ir[25:21], de_s);
    assign alu = (op == OP_SUB || op == OP_SUBI) ? x - y :
                 op == OP_AND ? x & y :
                 op == OP_OR ? x | y :
                 (op == OP_SLT || op == OP_SLTI) ? {31'd0, $signed(x) < $signed(y)} :
                 (op == OP_MUL || op == OP_MULI) ? x * y : x + y;
    assign taken = (op == OP_BEQZ && x == 32'd0) || (op == OP_BNEQZ && x != 32'd0);
    assign fd_hlt = fd_ir[31:26] == OP_HLT;
    // with bypass only a load in EX blocks its consumer; without it ID waits until the producer reaches WB
    assign stall = FWD ? (op == OP_LW && reads(fd_ir, de_ir[25:21])) :
                   (writes(de_ir) && reads(fd_ir, de_ir[25:21])) || (em_wr && reads(fd_ir, em_dst));
    assign bus.addr = em_alu[9:0];
    assign bus.wdata = em_sd;
    assign bus.we = em_st;

    // pipeline advance: taken branch flushes IF/ID and ID/EX, HLT in ID freezes fetch for good
    always_ff @(posedge clk_x or posedge rst)
        if (rst) begin
            pc <= '0;
            fd_ir <= '0;
            fd_npc <= '0;
            de_ir <= '0;
            de_npc <= '0;
            de_a <= '0;
            de_b <= '0;
            de_s <= '0;
            em_alu <= '0;
            em_sd <= '0;
            em_dst <= '0;
            em_wr <= 1'b0;
            em_ld <= 1'b0;
            em_st <= 1'b0;
            em_hlt <= 1'b0;
            mw_res <= '0;
            mw_dst <= '0;
            mw_wr <= 1'b0;
            halted <= 1'b0;
            stop <= 1'b0;
        end else begin
            pc <= taken ? de_npc + de_ir[9:0] : (stall || fd_hlt || stop) ? pc : pc + 10'd1;
            fd_ir <= (taken || fd_hlt || stop) ? 32'd0 : stall ? fd_ir : f_ir;
            fd_npc <= stall ? fd_npc : pc + 10'd1;
            stop <= stop || (fd_hlt && !taken);
            de_ir <= (taken || stall) ? 32'd0 : fd_ir;
            de_npc <= fd_npc;
            de_a <= qb;
            de_b <= qc;
            de_s <= qa;
            em_alu <= alu;
            em_sd <= s;
            em_dst <= de_ir[25:21];
            em_wr <= writes(de_ir);
            em_ld <= op == OP_LW;
            em_st <= op == OP_SW;
            em_hlt <= op == OP_HLT;
            mw_res <= em_ld ? bus.rdata : em_alu;
            mw_dst <= em_dst;
            mw_wr <= em_wr;
            halted <= halted || em_hlt;
        end
endmodule

// File: tb/tb_mips32.sv
// tb_mips32: table-driven ALU vectors plus directed pipeline sequences for mips32
module tb_mips32;
    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010, OP_OR = 6'b000011;
    localparam logic [5:0] OP_SLT = 6'b000100, OP_MUL = 6'b000101, OP_ADDI = 6'b001010, OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100, OP_MULI = 6'b010010, OP_LW = 6'b110000;
    localparam logic [5:0] OP_BEQZ = 6'b110100, OP_BNEQZ = 6'b110101;
    localparam logic [31:0] HLT = 32'hFC000000;
`ifdef MIPS32_FORWARD_EN
    localparam int BUB = 1;
`else
    localparam int BUB = 2;
`endif

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp;
    } vec_t;

    logic clk_x = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    mips32 dut (.clk_x(clk_x), .rst(rst));

    always #5 clk_x = ~clk_x;

    function automatic logic [31:0] rt(input logic [5:0] o, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {o, a, b, c, 11'd0};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] o, input logic [4:0] a, input logic [4:0] b, input logic [15:0] imm);
        return {o, a, b, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic hold_reset();
        @(negedge clk_x);
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) dut.i_f.mem[i] = 32'd0;
    endtask

    task automatic release_reset();
        @(negedge clk_x);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!dut.halted && cyc < budget) begin
            @(posedge clk_x);
            #1;
            cyc++;
        end
        check(name, {31'd0, dut.halted}, 32'd1);
    endtask

    task automatic load_main();
        dut.i_f.mem[1] = 32'hC0200001;
        dut.i_f.mem[2] = 32'hC0400002;
        dut.i_f.mem[3] = 32'h00611000;
        dut.i_f.mem[4] = 32'h48830002;
        dut.i_f.mem[5] = 32'hC4800003;
        dut.i_f.mem[6] = 32'hD0000005;
        dut.i_f.mem[12] = 32'hFFFF0005;
        dut.max.data[1] = 32'h5;
        dut.max.data[2] = 32'h7;
    endtask

    initial begin
        vec_t v[15];
        int c1, c2;
        v[0] = '{"add", rt(OP_ADD, 10, 8, 9), 32'd5, 32'd7, 32'h0000000C};
        v[1] = '{"sub", rt(OP_SUB, 10, 8, 9), 32'd5, 32'd7, 32'hFFFFFFFE};
        v[2] = '{"and", rt(OP_AND, 10, 8, 9), 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        v[3] = '{"or", rt(OP_OR, 10, 8, 9), 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
        v[4] = '{"slt_neg_lt", rt(OP_SLT, 10, 8, 9), 32'hFFFFFFFF, 32'd1, 32'd1};
        v[5] = '{"slt_pos_ge", rt(OP_SLT, 10, 8, 9), 32'd1, 32'hFFFFFFFF, 32'd0};
        v[6] = '{"mul_wrap", rt(OP_MUL, 10, 8, 9), 32'h00010000, 32'h00010000, 32'd0};
        v[7] = '{"mul_neg", rt(OP_MUL, 10, 8, 9), 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA};
        v[8] = '{"addi_negimm", it(OP_ADDI, 10, 8, 16'hFFFF), 32'd5, 32'd0, 32'd4};
        v[9] = '{"subi", it(OP_SUBI, 10, 8, 16'h0007), 32'd5, 32'd0, 32'hFFFFFFFE};
        v[10] = '{"slti_lt", it(OP_SLTI, 10, 8, 16'h0003), 32'hFFFFFFFB, 32'd0, 32'd1};
        v[11] = '{"slti_ge", it(OP_SLTI, 10, 8, 16'hFFFB), 32'd3, 32'd0, 32'd0};
        v[12] = '{"muli_neg", it(OP_MULI, 10, 8, 16'hFFFD), 32'd7, 32'd0, 32'hFFFFFFEB};
        v[13] = '{"undef_3e_nop", it(6'h3E, 10, 8, 16'h0001), 32'd5, 32'd7, 32'hDEADBEEF};
        v[14] = '{"undef_06_nop", rt(6'h06, 10, 8, 9), 32'd5, 32'd7, 32'hDEADBEEF};

        #1;
        check("reset_pc", {22'd0, dut.pc}, 32'd0);
        check("reset_halted", {31'd0, dut.halted}, 32'd0);
        check("reset_ifid_nop", dut.fd_ir, 32'd0);

        for (int i = 0; i < 15; i++) begin
            hold_reset();
            dut.i_f.mem[0] = v[i].ir;
            dut.i_f.mem[1] = HLT;
            dut.id.reg_b[8] = v[i].b;
            dut.id.reg_b[9] = v[i].c;
            dut.id.reg_b[10] = 32'hDEADBEEF;
            release_reset();
            run_to_halt({v[i].name, "_halt"}, 60, c1);
            check(v[i].name, dut.id.reg_b[10], v[i].exp);
        end

        hold_reset();
        load_main();
        for (int i = 7; i < 12; i++) dut.i_f.mem[i] = it(OP_ADDI, 5, 0, 16'h0001);
        dut.max.data[3] = 32'd0;
        dut.id.reg_b[5] = 32'h55;
        release_reset();
        repeat (35) @(posedge clk_x);
        #1;
        check("main_r1", dut.id.reg_b[1], 32'h5);
        check("main_r2", dut.id.reg_b[2], 32'h7);
        check("main_r3", dut.id.reg_b[3], 32'hC);
        check("main_r4", dut.id.reg_b[4], 32'h18);
        check("main_data3", dut.max.data[3], 32'h18);
        check("main_halted", {31'd0, dut.halted}, 32'd1);
        check("main_pc", {22'd0, dut.pc}, 32'd13);
        check("flush_r5", dut.id.reg_b[5], 32'h55);

        hold_reset();
        dut.i_f.mem[0] = it(OP_LW, 1, 0, 16'h0004);
        dut.i_f.mem[1] = rt(OP_ADD, 3, 1, 2);
        dut.i_f.mem[2] = HLT;
        dut.max.data[4] = 32'd100;
        dut.id.reg_b[2] = 32'd23;
        dut.id.reg_b[3] = 32'd0;
        release_reset();
        run_to_halt("lu_dep_halt", 60, c1);
        check("lu_dep_sum", dut.id.reg_b[3], 32'd123);
        hold_reset();
        dut.i_f.mem[0] = it(OP_LW, 1, 0, 16'h0004);
        dut.i_f.mem[1] = rt(OP_ADD, 3, 2, 2);
        dut.i_f.mem[2] = HLT;
        dut.id.reg_b[3] = 32'd0;
        release_reset();
        run_to_halt("lu_indep_halt", 60, c2);
        check("lu_indep_sum", dut.id.reg_b[3], 32'd46);
        check("lu_bubbles", c1 - c2, BUB);

        hold_reset();
        dut.i_f.mem[0] = it(OP_ADDI, 0, 0, 16'h0009);
        dut.i_f.mem[1] = rt(OP_ADD, 6, 0, 0);
        dut.i_f.mem[2] = HLT;
        dut.id.reg_b[6] = 32'h66;
        release_reset();
        run_to_halt("r0_halt", 60, c1);
        check("r0_r6", dut.id.reg_b[6], 32'd0);

        hold_reset();
        dut.i_f.mem[0] = it(OP_ADDI, 11, 0, 16'h0002);
        dut.i_f.mem[1] = it(OP_BNEQZ, 0, 11, 16'h0001);
        dut.i_f.mem[2] = it(OP_ADDI, 12, 0, 16'h0009);
        dut.i_f.mem[3] = it(OP_BEQZ, 0, 11, 16'h0007);
        dut.i_f.mem[4] = it(OP_ADDI, 13, 0, 16'h0005);
        dut.i_f.mem[5] = HLT;
        dut.id.reg_b[12] = 32'h77;
        dut.id.reg_b[13] = 32'd0;
        release_reset();
        run_to_halt("br_halt", 60, c1);
        check("bneqz_taken_skip", dut.id.reg_b[12], 32'h77);
        check("beqz_not_taken", dut.id.reg_b[13], 32'd5);

        hold_reset();
        dut.i_f.mem[0] = HLT;
        dut.i_f.mem[1] = it(OP_ADDI, 7, 0, 16'h0003);
        dut.i_f.mem[2] = it(OP_ADDI, 7, 0, 16'h0003);
        dut.id.reg_b[7] = 32'h70;
        release_reset();
        run_to_halt("hlt_halt", 60, c1);
        repeat (10) @(posedge clk_x);
        #1;
        check("hlt_pc_frozen", {22'd0, dut.pc}, 32'd1);
        check("hlt_r7", dut.id.reg_b[7], 32'h70);
        check("hlt_persist", {31'd0, dut.halted}, 32'd1);

        hold_reset();
        load_main();
        dut.max.data[3] = 32'hBB;
        dut.id.reg_b[1] = 32'h11;
        dut.id.reg_b[2] = 32'h22;
        dut.id.reg_b[4] = 32'h44;
        release_reset();
        repeat (5) @(posedge clk_x);
        @(negedge clk_x);
        rst = 1'b1;
        #1;
        check("rst_pc_now", {22'd0, dut.pc}, 32'd0);
        check("rst_halted_now", {31'd0, dut.halted}, 32'd0);
        repeat (3) @(posedge clk_x);
        #1;
        check("rst_pc_held", {22'd0, dut.pc}, 32'd0);
        check("rst_r1_kept", dut.id.reg_b[1], 32'h11);
        check("rst_r2_kept", dut.id.reg_b[2], 32'h22);
        check("rst_r4_kept", dut.id.reg_b[4], 32'h44);
        check("rst_data3_kept", dut.max.data[3], 32'hBB);
        release_reset();
        run_to_halt("rerun_halt", 60, c1);
        check("rerun_r1", dut.id.reg_b[1], 32'h5);
        check("rerun_r4", dut.id.reg_b[4], 32'h18);
        check("rerun_data3", dut.max.data[3], 32'h18);
        @(negedge clk_x);
        rst = 1'b1;
        #1;
        check("rst_clears_halted", {31'd0, dut.halted}, 32'd0);
        check("rst_clears_pc", {22'd0, dut.pc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
